// File: rtl/err_window_sequencer_if.sv
// rtl/err_window_sequencer_if.sv - report byte stream (data/valid/ready) between sequencer and TX path
interface err_window_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/err_window_sequencer.sv
// rtl/err_window_sequencer.sv - per-window clear/pass/drain/snapshot/report sequencer for the RX error detector
// ERR_REPORT_CHECKSUM_EN: append an XOR byte over the 16 counter bytes (18-byte report).
module err_window_sequencer #(
  parameter int unsigned WINDOW_PKTS  = 200,
  parameter int unsigned CLR_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          rx_en_in,
  input  logic [7:0]                    rx_data_in,
  output logic                          rx_en_out,
  output logic [7:0]                    rx_data_out,
  output logic                          det_clr,
  input  logic [31:0]                   det_count,
  input  logic [31:0]                   det_ok,
  input  logic [31:0]                   det_ng,
  input  logic [31:0]                   det_lost,
  err_window_sequencer_if.master        tx,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_SNAP  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

`ifdef ERR_REPORT_CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'd17;
`else
  localparam logic [4:0] LAST_IDX = 5'd16;
`endif

  state_t         state_q, state_d;
  logic           gate_q, gate_d;
  logic           rx_en_q;
  logic [7:0]     rx_data_q;
  logic           clr_armed_q, clr_armed_d;
  logic [31:0]    clr_cnt_q, clr_cnt_d;
  logic [31:0]    drain_cnt_q, drain_cnt_d;
  logic [31:0]    pkt_cnt_q, pkt_cnt_inc;
  logic [127:0]   snap_q;
  logic [4:0]     byte_idx_q, byte_idx_d;
  logic           done_q, done_d;
  logic           snap_load, pkt_clear;
  logic           pkt_end, window_hit, tx_accept;
  logic [7:0]     sel_byte;

  // A passed packet ends when the forwarded enable is high and the source has gone idle.
  assign pkt_end     = rx_en_q & ~rx_en_in;
  assign pkt_cnt_inc = (pkt_cnt_q == 32'hFFFF_FFFF) ? pkt_cnt_q : pkt_cnt_q + 32'd1;
  assign window_hit  = (WINDOW_PKTS != 0) && pkt_end && (pkt_cnt_inc == 32'(WINDOW_PKTS));
  assign tx_accept   = tx.tx_valid & tx.tx_ready;

  always_comb begin
    state_d     = state_q;
    clr_armed_d = clr_armed_q;
    clr_cnt_d   = clr_cnt_q;
    drain_cnt_d = drain_cnt_q;
    byte_idx_d  = byte_idx_q;
    done_d      = 1'b0;
    snap_load   = 1'b0;
    pkt_clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          clr_armed_d = 1'b0;
          clr_cnt_d   = 32'd0;
        end
      end
      S_CLEAR: begin
        if (!clr_armed_q) begin
          if (!rx_en_in) clr_armed_d = 1'b1;
        end else if (clr_cnt_q == 32'(CLR_CYCLES - 1)) begin
          clr_armed_d = 1'b0;
          state_d     = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (stop || window_hit) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 32'd0;
        end
      end
      S_DRAIN: begin
        // The settle period only starts once the in-flight packet has finished and the gate shut.
        if (!gate_q) begin
          if (drain_cnt_q == 32'(DRAIN_CYCLES - 1)) state_d = S_SNAP;
          else drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end
      S_SNAP: begin
        snap_load  = 1'b1;
        byte_idx_d = 5'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_accept) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            pkt_clear = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Gate follows the window but only moves in an idle gap, so packets are never cut.
    gate_d = rx_en_in ? gate_q : (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gate_q      <= 1'b0;
      rx_en_q     <= 1'b0;
      rx_data_q   <= 8'd0;
      clr_armed_q <= 1'b0;
      clr_cnt_q   <= 32'd0;
      drain_cnt_q <= 32'd0;
      pkt_cnt_q   <= 32'd0;
      snap_q      <= 128'd0;
      byte_idx_q  <= 5'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      rx_en_q     <= rx_en_in & gate_q;
      rx_data_q   <= rx_data_in;
      clr_armed_q <= clr_armed_d;
      clr_cnt_q   <= clr_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      byte_idx_q  <= byte_idx_d;
      done_q      <= done_d;
      if (pkt_clear) pkt_cnt_q <= 32'd0;
      else if (pkt_end && (state_q == S_RUN || state_q == S_DRAIN)) pkt_cnt_q <= pkt_cnt_inc;
      if (snap_load) snap_q <= {det_count, det_ok, det_ng, det_lost};
    end
  end

`ifdef ERR_REPORT_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'd0;
    for (int k = 0; k < 16; k++) csum = csum ^ snap_q[k*8 +: 8];
  end
`endif

  // Byte 0 is the header, bytes 1..16 walk the snapshot MSB-first.
  always_comb begin
    sel_byte = HDR_BYTE;
    for (int k = 0; k < 16; k++) begin
      if (byte_idx_q == 5'(k + 1)) sel_byte = snap_q[(15 - k)*8 +: 8];
    end
`ifdef ERR_REPORT_CHECKSUM_EN
    if (byte_idx_q == 5'd17) sel_byte = csum;
`endif
  end

  assign tx.tx_valid = (state_q == S_SEND);
  assign tx.tx_data  = (state_q == S_SEND) ? sel_byte : 8'd0;
  assign rx_en_out   = rx_en_q;
  assign rx_data_out = rx_data_q;
  assign det_clr     = (state_q == S_CLEAR) && clr_armed_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign state       = state_q;

endmodule

// File: tb/tb_err_window_sequencer.sv
// tb/tb_err_window_sequencer.sv - scoreboard bench for err_window_sequencer
module tb_err_window_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        rx_en_in = 1'b0;
  logic [7:0]  rx_data_in = 8'd0;
  logic        rx_en_out;
  logic [7:0]  rx_data_out;
  logic        det_clr;
  logic [31:0] det_count = 32'd0;
  logic [31:0] det_ok = 32'd0;
  logic [31:0] det_ng = 32'd0;
  logic [31:0] det_lost = 32'd0;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  err_window_sequencer_if tif ();

  err_window_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .rx_en_in    (rx_en_in),
    .rx_data_in  (rx_data_in),
    .rx_en_out   (rx_en_out),
    .rx_data_out (rx_data_out),
    .det_clr     (det_clr),
    .det_count   (det_count),
    .det_ok      (det_ok),
    .det_ng      (det_ng),
    .det_lost    (det_lost),
    .tx          (tif),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #4 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         fwd_pkts = 0;
  int         fwd_len = 0;
  int         clr_hi = 0;
  int         clr_viol = 0;
  int         pkt_len = 15;
  bit         ready_toggle = 1'b0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Forwarded-stream monitor: data follows input by one cycle, every packet arrives whole.
  logic       prev_en = 1'b0;
  logic [7:0] last_in = 8'd0;
  always @(negedge clk) begin
    if (!rst) begin
      fwd_len = 0;
      prev_en = 1'b0;
    end else begin
      if (rx_en_out) begin
        check("fwd_data", rx_data_out, last_in);
        fwd_len++;
      end else if (prev_en) begin
        check("fwd_pkt_len", fwd_len, pkt_len);
        fwd_pkts++;
        fwd_len = 0;
      end
      prev_en = rx_en_out;
      if (det_clr) begin
        clr_hi++;
        if (rx_en_in) clr_viol++;
      end
    end
    last_in = rx_data_in;
  end

  // Report monitor: pops the scoreboard on each accepted byte, checks stall stability and done width.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_done = 1'b0;
  logic [7:0] e;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        check("stall_valid_hold", tif.tx_valid, 1);
        check("stall_data_hold", tif.tx_data, prev_data);
      end
      if (tif.tx_valid && tif.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report_byte actual=%0h expected=none", tif.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("report_byte", tif.tx_data, e);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 0);
        check("done_valid_low", tif.tx_valid, 0);
      end
      prev_stall = tif.tx_valid && !tif.tx_ready;
      prev_data  = tif.tx_data;
      prev_done  = done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  initial begin
    tif.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tif.tx_ready = ready_toggle ? ~tif.tx_ready : 1'b1;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    idle(1);
    stop = 1'b0;
  endtask

  task automatic drive_pkt(input int len, input int gap, input int tag, input int pulse_at, input bit is_stop);
    for (int i = 0; i < len; i++) begin
      rx_en_in   = 1'b1;
      rx_data_in = 8'(tag * 16 + i);
      start      = (pulse_at == i) && !is_stop;
      stop       = (pulse_at == i) && is_stop;
      idle(1);
    end
    rx_en_in = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    idle(gap);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) idle(1);
    check("done_reached", done_cnt, target);
  endtask

  task automatic wait_send(input int budget);
    for (int i = 0; i < budget && state != 3'd5; i++) idle(1);
    check("send_reached", state, 5);
  endtask

  task automatic push_report();
    logic [127:0] v;
    v = {det_count, det_ok, det_ng, det_lost};
    exp_q.push_back(8'hA5);
    for (int k = 15; k >= 0; k--) exp_q.push_back(v[k*8 +: 8]);
`ifdef ERR_REPORT_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'd0;
      for (int k = 0; k < 16; k++) x = x ^ v[k*8 +: 8];
      exp_q.push_back(x);
    end
`endif
  endtask

  logic [7:0] rep2 [17] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h00, 8'h00, 8'hC3,
                            8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] rep6 [17] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                            8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04};

  initial begin
    idle(3);
    check("rst_rx_en_out", rx_en_out, 0);
    check("rst_rx_data_out", rx_data_out, 0);
    check("rst_det_clr", det_clr, 0);
    check("rst_tx_valid", tif.tx_valid, 0);
    check("rst_tx_data", tif.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state, 0);
    rst = 1'b1;
    idle(2);

    // Reset while a packet is being forwarded.
    pulse_start();
    idle(10);
    check("t1_state_run", state, 2);
    rx_en_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data_in = 8'(i);
      idle(1);
    end
    check("t1_fwd_active", rx_en_out, 1);
    #1 rst = 1'b0;
    #1;
    check("t1_async_rx_en_out", rx_en_out, 0);
    check("t1_async_busy", busy, 0);
    check("t1_async_state", state, 0);
    check("t1_async_det_clr", det_clr, 0);
    check("t1_async_tx_valid", tif.tx_valid, 0);
    idle(1);
    rx_en_in = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    check("t1_state_after_release", state, 0);

    // Full 200-packet window.
    det_count = 32'd200; det_ok = 32'd195; det_ng = 32'd5; det_lost = 32'd0;
    fwd_pkts = 0; clr_hi = 0; clr_viol = 0;
    for (int k = 0; k < 17; k++) exp_q.push_back(rep2[k]);
    pulse_start();
    idle(10);
    for (int p = 0; p < 202; p++) drive_pkt(15, 10, p, -1, 1'b0);
    wait_done(1, 300);
    check("t2_fwd_pkts", fwd_pkts, 200);
    check("t2_clr_cycles", clr_hi, 2);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_idle", state, 0);

    // Start during a packet: clear waits, that packet is blocked.
    det_count = 32'h11223344; det_ok = 32'h55667788; det_ng = 32'h99AABBCC; det_lost = 32'hDDEEFF00;
    fwd_pkts = 0; clr_hi = 0; clr_viol = 0;
    push_report();
    drive_pkt(15, 10, 1, 2, 1'b0);
    drive_pkt(15, 10, 2, -1, 1'b0);
    drive_pkt(15, 10, 3, -1, 1'b0);
    pulse_stop();
    wait_done(2, 300);
    check("t3_fwd_pkts", fwd_pkts, 2);
    check("t3_clr_cycles", clr_hi, 2);
    check("t3_clr_in_pkt", clr_viol, 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Stop mid packet 42.
    det_count = 32'd42; det_ok = 32'd40; det_ng = 32'd2; det_lost = 32'd0;
    fwd_pkts = 0;
    push_report();
    pulse_start();
    idle(10);
    for (int p = 0; p < 45; p++) drive_pkt(15, 10, p, (p == 41) ? 6 : -1, 1'b1);
    wait_done(3, 300);
    check("t4_fwd_pkts", fwd_pkts, 42);
    check("t4_queue_empty", exp_q.size(), 0);

    // Throttled sink, start during SEND ignored.
    det_count = 32'h01234567; det_ok = 32'h89ABCDEF; det_ng = 32'hFEDCBA98; det_lost = 32'h76543210;
    fwd_pkts = 0;
    ready_toggle = 1'b1;
    push_report();
    pulse_start();
    idle(10);
    for (int p = 0; p < 3; p++) drive_pkt(15, 10, p, -1, 1'b0);
    pulse_stop();
    wait_send(100);
    pulse_start();
    wait_done(4, 300);
    idle(3);
    check("t5_state_idle", state, 0);
    check("t5_busy_low", busy, 0);
    check("t5_fwd_pkts", fwd_pkts, 3);
    check("t5_queue_empty", exp_q.size(), 0);
    ready_toggle = 1'b0;
    idle(2);

    // Counters 1/2/3/4 (checksum byte 04 when enabled).
    det_count = 32'd1; det_ok = 32'd2; det_ng = 32'd3; det_lost = 32'd4;
    for (int k = 0; k < 17; k++) exp_q.push_back(rep6[k]);
`ifdef ERR_REPORT_CHECKSUM_EN
    exp_q.push_back(8'h04);
`endif
    pulse_start();
    idle(10);
    for (int p = 0; p < 2; p++) drive_pkt(15, 10, p, -1, 1'b0);
    pulse_stop();
    wait_done(5, 300);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
